param_updown_counter: RTL and testbench
=======================================

PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, counter bit width (legal range 2..16).
REQ-002 SHALL provide parameter MODULUS, default 16, count sequence length (legal range 2..2^WIDTH).
REQ-003 SHALL provide port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL provide port clr  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port ld  input  1  active-high synchronous parallel load.
REQ-006 SHALL provide port p  input  1  count enable, parallel.
REQ-007 SHALL provide port t  input  1  count enable, trickle; also gates co.
REQ-008 SHALL provide port up  input  1  direction: 1 = up, 0 = down.
REQ-009 SHALL provide port D  input  WIDTH  parallel load data.
REQ-010 SHALL provide port Q  output  WIDTH  registered count value.
REQ-011 SHALL provide port co  output  1  combinational terminal-count / ripple-carry for cascading.
REQ-012 SHALL provide port ovf  output  1  registered sticky wrap flag.

Function
REQ-013 SHALL apply per-edge priority: clr > ld > count > hold.
REQ-014 SHALL count only when p=1 and t=1 and ld=0 and clr=0; otherwise Q holds.
REQ-015 SHALL, counting up: Q = MODULUS-1 -> 0, else Q+1.
REQ-016 SHALL, counting down: Q = 0 -> MODULUS-1, else Q-1.
REQ-017 SHALL, on ld=1: load Q = D when D < MODULUS, else Q = MODULUS-1 (clamp); no out-of-range state is ever reachable.
REQ-018 SHALL drive co = t & ((up & Q==MODULUS-1) | (~up & Q==0)), independent of p, zero latency.
REQ-019 SHALL set ovf on any edge where counting is enabled and Q is at the terminal value for the current direction.
REQ-020 SHALL clear ovf on clr or ld; ld together with a terminal count clears ovf (ld wins).
REQ-021 SHALL take the direction change immediately: up toggled at terminal re-evaluates co in the same cycle and the next step in the new direction.
REQ-022 SHALL have Q update one clk edge after its qualifying inputs (latency 1); ovf likewise.
REQ-023 SHALL support cascading: stage n+1 t = stage n co, with a shared p, giving a MODULUS^k counter.

Reset
REQ-024 SHALL, on clr=1 at a rising clk edge: Q = 0, ovf = 0, regardless of ld, p, t, up or D.
REQ-025 SHALL, with clr held high, drive co = t & ~up (Q=0 is the down-terminal).
REQ-026 SHALL abort any count or load in progress on clr mid-sequence, with no residual state.

Configuration
REQ-027 SHALL honour macro PARAM_COUNTER_SAT_EN.
REQ-028 SHALL, with PARAM_COUNTER_SAT_EN defined: at the terminal value with counting enabled, hold Q (saturate) instead of wrapping; co and ovf behave as in REQ-018/019.
REQ-029 SHALL, without PARAM_COUNTER_SAT_EN: wrap per REQ-015/016.

Verification
REQ-030 SHALL cover: WIDTH=4, MODULUS=10, clr, then up=1, p=t=1 for 12 edges -> Q 0..9,0,1; co=1 only while Q=9; ovf=1 from edge 10 on.
REQ-031 SHALL cover: MODULUS=10, ld=1, D=4'hC -> Q=9 (clamp), ovf=0; then up=0 for 3 edges -> Q 8,7,6.
REQ-032 SHALL cover: Q=5, p=1, t=0 -> Q holds 5, co=0; p=0, t=1 -> Q holds 5.
REQ-033 SHALL cover: Q=9, up=1, p=t=1, ld=1, D=3 and clr=1 together -> Q=0, ovf=0; same with clr=0 -> Q=3, ovf=0.
REQ-034 SHALL cover: two cascaded MODULUS=10 stages (low co to high t), 100 enabled edges from 0 -> {high,low} run 00..99 then 00; high co=1 only at 99.
REQ-035 SHALL cover: PARAM_COUNTER_SAT_EN defined, MODULUS=10, Q=9, up=1, p=t=1 for 3 edges -> Q stays 9, co=1, ovf=1.

Source files
------------

// File: rtl/param_updown_counter.sv
// Modulo-MODULUS up/down counter with parallel load, p/t enables, cascade carry and sticky wrap flag.
// Optional macro PARAM_COUNTER_SAT_EN: hold at the terminal value instead of wrapping.
module param_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ld,
  input  logic             p,
  input  logic             t,
  input  logic             up,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             co,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] q_reg, q_next;
  logic             ovf_reg, ovf_next;
  logic             at_term;
  logic             count_en;

  assign at_term  = up ? (q_reg == TOP) : (q_reg == '0);
  assign count_en = p & t;
  assign co       = t & at_term;
  assign Q        = q_reg;
  assign ovf      = ovf_reg;

  always_comb begin
    q_next   = q_reg;
    ovf_next = ovf_reg;
    if (ld) begin
      // Out-of-range load data clamps to the top of the sequence.
      q_next   = ({1'b0, D} < MOD_EXT) ? D : TOP;
      ovf_next = 1'b0;
    end else if (count_en) begin
      if (at_term) begin
        ovf_next = 1'b1;
`ifdef PARAM_COUNTER_SAT_EN
        q_next   = q_reg;
`else
        q_next   = up ? '0 : TOP;
`endif
      end else begin
        q_next = up ? (q_reg + 1'b1) : (q_reg - 1'b1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      q_reg   <= '0;
      ovf_reg <= 1'b0;
    end else begin
      q_reg   <= q_next;
      ovf_reg <= ovf_next;
    end
  end

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter (MODULUS=10) plus a two-stage cascade.
module tb_param_updown_counter;

  logic       clk;
  logic       clr, ld, p, t, up;
  logic [3:0] D;
  logic [3:0] Q;
  logic       co, ovf;

  logic       c_clr, c_p, c_t, c_up, c_ld;
  logic [3:0] c_d;
  logic [3:0] lo_q, hi_q;
  logic       lo_co, hi_co, lo_ovf, hi_ovf;

  int n_cmp = 0;
  int n_err = 0;

  param_updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .clr(clr), .ld(ld), .p(p), .t(t), .up(up), .D(D),
    .Q(Q), .co(co), .ovf(ovf)
  );

  param_updown_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
    .clk(clk), .clr(c_clr), .ld(c_ld), .p(c_p), .t(c_t), .up(c_up), .D(c_d),
    .Q(lo_q), .co(lo_co), .ovf(lo_ovf)
  );

  param_updown_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
    .clk(clk), .clr(c_clr), .ld(c_ld), .p(c_p), .t(lo_co), .up(c_up), .D(c_d),
    .Q(hi_q), .co(hi_co), .ovf(hi_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    $display("edge: clr=%0b ld=%0b p=%0b t=%0b up=%0b D=%0d -> Q=%0d co=%0b ovf=%0b",
             clr, ld, p, t, up, D, Q, co, ovf);
  endtask

  task automatic cstep();
    @(posedge clk);
    #1;
    $display("cascade edge: hi=%0d lo=%0d hi_co=%0b", hi_q, lo_q, hi_co);
  endtask

  initial begin
    clr = 1'b1; ld = 1'b0; p = 1'b0; t = 1'b0; up = 1'b1; D = 4'd0;
    c_clr = 1'b1; c_p = 1'b0; c_t = 1'b1; c_up = 1'b1; c_ld = 1'b0; c_d = 4'd0;

    // Reset state
    step();
    check("rst_q", Q, 0);
    check("rst_ovf", ovf, 0);
    check("rst_co_t0", co, 0);
    t = 1'b1; up = 1'b0; #1;
    check("rst_co_down", co, 1);
    up = 1'b1; #1;
    check("rst_co_up", co, 0);

`ifndef PARAM_COUNTER_SAT_EN
    // Count up 12 edges: 0..9 then wrap 0,1
    clr = 1'b0; p = 1'b1; t = 1'b1; up = 1'b1;
    begin
      int exp_q;
      exp_q = 0;
      for (int i = 1; i <= 12; i++) begin
        check("up_co", co, (exp_q == 9) ? 1 : 0);
        step();
        exp_q = (exp_q == 9) ? 0 : exp_q + 1;
        check("up_q", Q, exp_q);
        check("up_ovf", ovf, (i >= 10) ? 1 : 0);
      end
    end
`else
    clr = 1'b0;
`endif

    // Clamped load then count down
    p = 1'b1; t = 1'b1; ld = 1'b1; D = 4'hC;
    step();
    check("ld_clamp_q", Q, 9);
    check("ld_clamp_ovf", ovf, 0);
    ld = 1'b0; up = 1'b0;
    step(); check("dn_q1", Q, 8);
    step(); check("dn_q2", Q, 7);
    step(); check("dn_q3", Q, 6);
    check("dn_ovf", ovf, 0);
    p = 1'b0; ld = 1'b1; D = 4'hF;
    step(); check("ld_clamp_f", Q, 9);
    D = 4'd10;
    step(); check("ld_clamp_10", Q, 9);
    D = 4'd8;
    step(); check("ld_inrange", Q, 8);

    // Direction change at terminal
    D = 4'd9;
    step();
    ld = 1'b0; up = 1'b1; t = 1'b1; #1;
    check("dir_co_up", co, 1);
    up = 1'b0; #1;
    check("dir_co_dn", co, 0);
    p = 1'b1;
    step();
    check("dir_q", Q, 8);
    check("dir_ovf", ovf, 0);

    // Hold cases
    p = 1'b0; ld = 1'b1; D = 4'd5;
    step();
    ld = 1'b0; p = 1'b1; t = 1'b0; up = 1'b1;
    step();
    check("hold_t0_q", Q, 5);
    check("hold_t0_co", co, 0);
    p = 1'b0; t = 1'b1;
    step();
    check("hold_p0_q", Q, 5);
    check("hold_p0_co", co, 0);

`ifndef PARAM_COUNTER_SAT_EN
    // Down wrap sets ovf; clr beats ld and count
    ld = 1'b1; D = 4'd0;
    step();
    ld = 1'b0; up = 1'b0; p = 1'b1; t = 1'b1;
    step();
    check("dnwrap_q", Q, 9);
    check("dnwrap_ovf", ovf, 1);
    up = 1'b1; ld = 1'b1; D = 4'd3; clr = 1'b1; #1;
    check("pri_co", co, 1);
    step();
    check("pri_clr_q", Q, 0);
    check("pri_clr_ovf", ovf, 0);
    clr = 1'b0; ld = 1'b0; up = 1'b0;
    step();
    check("dnwrap2_q", Q, 9);
    check("dnwrap2_ovf", ovf, 1);
    up = 1'b1; ld = 1'b1; D = 4'd3;
    step();
    check("pri_ld_q", Q, 3);
    check("pri_ld_ovf", ovf, 0);
    ld = 1'b0; p = 1'b0;
`else
    // Saturation at terminal
    ld = 1'b1; D = 4'd9;
    step();
    ld = 1'b0; up = 1'b1; p = 1'b1; t = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("sat_q", Q, 9);
      check("sat_co", co, 1);
      check("sat_ovf", ovf, 1);
    end
    p = 1'b0;
`endif

`ifndef PARAM_COUNTER_SAT_EN
    // Two-stage cascade: 00..99 then 00
    cstep();
    check("casc_rst", {24'd0, hi_q, lo_q}, 0);
    c_clr = 1'b0; c_p = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      check("casc_hi_co", hi_co, ((i - 1) == 99) ? 1 : 0);
      cstep();
      check("casc_val", hi_q * 10 + lo_q, i % 100);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
